// File: rtl/cpc_bus_initiator.sv
// CPC Z80-style bus initiator: turns single requests into T1/T2/TW/T3
// memory, I/O and bank-select cycles with registered, glitch-free strobes.
module cpc_bus_initiator (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_ext,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        MREQ_B,
  output logic        IOREQ_B,
  output logic        RD_B,
  output logic        WR_B,
  output logic        RAMRD_B,
  output logic        M1_B,
  output logic        RFSH_B,
  input  logic        READY,
  input  logic        RAMDIS,
  output logic [7:0]  bank_q
);

  typedef enum logic [2:0] {
    IDLE, T1, T2, TW, T3
  } state_t;

  localparam logic [1:0] MEM_RD = 2'b00;
  localparam logic [1:0] MEM_WR = 2'b01;
  localparam logic [1:0] BANK   = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  dout_q, dout_d;
  logic        doe_q, doe_d;
  // {MREQ, IOREQ, RD, WR, RAMRD}, active low
  logic [4:0]  strb_q, strb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ext_q, ext_d;
  logic [7:0]  bank_d;
  logic        busy, late, is_io, is_rd;

  // Sequencer: next state and request capture at acceptance.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = T1;
        type_d  = req_type;
        if (req_type == BANK) begin
          addr_d = 16'h7F00;
          data_d = {2'b11, req_wdata[5:0]};
        end else begin
          addr_d = req_addr;
          data_d = req_wdata;
        end
      end
      T1: state_d = T2;
      // I/O always takes one TW regardless of READY
      T2: state_d = (type_q[1] || !READY) ? TW : T3;
      TW: if (READY) state_d = T3;
      T3: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs derived from the state being entered, so they register cleanly.
  always_comb begin
    busy   = (state_d != IDLE);
    late   = (state_d == T2) || (state_d == TW) || (state_d == T3);
    is_io  = type_d[1];
    is_rd  = (type_d == MEM_RD);
    a_d    = busy ? addr_d : 16'h0000;
    doe_d  = busy && !is_rd;
    dout_d = doe_d ? data_d : 8'h00;
    strb_d = 5'b11111;
    strb_d[4] = !(busy && !is_io);
    strb_d[3] = !(late && is_io);
    strb_d[2] = !(busy && is_rd);
    strb_d[1] = !(late && (is_io || type_d == MEM_WR));
    strb_d[0] = !(busy && is_rd);
  end

  // Completion: response pulse, read capture and bank shadow at end of T3.
  always_comb begin
    rsp_valid_d = (state_q == T3);
    rdata_d     = rdata_q;
    ext_d       = ext_q;
    bank_d      = bank_q;
    if (state_q == T3) begin
      if (type_q == MEM_RD) begin
        rdata_d = D_in;
        ext_d   = RAMDIS;
      end
      if (type_q[1] && addr_q[15:8] == 8'h7F && data_q[7:6] == 2'b11)
        bank_d = data_q;
    end
  end

  // All state and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      type_q      <= 2'b00;
      addr_q      <= 16'h0000;
      data_q      <= 8'h00;
      a_q         <= 16'h0000;
      dout_q      <= 8'h00;
      doe_q       <= 1'b0;
      strb_q      <= 5'b11111;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
      ext_q       <= 1'b0;
      bank_q      <= 8'hC0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      a_q         <= a_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
      strb_q      <= strb_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      ext_q       <= ext_d;
      bank_q      <= bank_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_ext   = ext_q;
  assign A         = a_q;
  assign D_out     = dout_q;
  assign D_oe      = doe_q;
  assign MREQ_B    = strb_q[4];
  assign IOREQ_B   = strb_q[3];
  assign RD_B      = strb_q[2];
  assign WR_B      = strb_q[1];
  assign RAMRD_B   = strb_q[0];
  assign M1_B      = 1'b1;
  assign RFSH_B    = 1'b1;

endmodule
